chunked_adder: RTL
==================

Name: chunked_adder

Overview:
- Multi-cycle, parametrised successor to the single-bit full adder used in the 8-bit ALU.
- Adds or subtracts two WIDTH-bit operands, CHUNK bits per clock, least-significant chunk first, using one shared CHUNK-bit adder slice with a registered carry.
- Sits in the ALU datapath as the arithmetic unit behind a start/done handshake.
- Also produces carry, signed-overflow and zero flags.

Parameters:
- WIDTH, 8, operand and result width in bits. Must be ≥ 2.
- CHUNK, 1, bits processed per cycle. Must divide WIDTH exactly. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new operation; sampled on a rising edge.
- a  input  WIDTH  operand A, captured when start is accepted.
- b  input  WIDTH  operand B, captured when start is accepted.
- c_in  input  1  carry-in for add, captured with the operands.
- sub  input  1  1 = A − B, 0 = A + B + c_in; captured with the operands.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the result becomes valid.
- sum  output  WIDTH  result.
- c_out  output  1  carry out of the MSB. For subtract, 1 means no borrow.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  high when sum == 0.

Behaviour:
- Reset (asynchronous, takes effect immediately on rst_n low):
  - state = IDLE.
  - busy = 0, done = 0, sum = 0, c_out = 0, ovf = 0, zero = 0.
  - Internal operand registers, carry register and chunk counter are cleared.
- States are IDLE, RUN and DONE.
- IDLE:
  - start = 1 at an edge latches a, b, c_in and sub.
  - Effective B = sub ? ~b : b. Initial carry = sub ? 1 : c_in, so c_in is ignored when sub = 1.
  - Counter is cleared to 0; next state is RUN with busy = 1.
- RUN:
  - Each edge adds chunk[counter] of A, chunk[counter] of effective B and the carry register.
  - The CHUNK result bits are written into the internal result register at position counter. The carry register is updated and the counter increments.
  - On the edge that processes chunk NCHUNK−1:
    - sum, c_out, ovf and zero are updated from the final values.
    - ovf uses the carry into bit WIDTH−1 captured during the last chunk.
    - Next state is DONE: busy = 0, done = 1.
- DONE:
  - Lasts exactly one cycle, then returns to IDLE. done returns to 0.
  - start during the DONE cycle is accepted exactly as in IDLE, allowing back-to-back operations.
- Latency:
  - start sampled at edge E0 → done high after edge E_NCHUNK.
  - busy is high from E0 to E_NCHUNK.
  - Throughput is one result every NCHUNK+1 cycles.
- start while busy = 1 is ignored. Operands, mode and progress are unaffected, and no request is queued.
- Output registers (sum, c_out, ovf, zero) change only on the completion edge. They hold their value through IDLE and through the next operation's RUN phase.
- Changes on a, b, c_in or sub after acceptance have no effect on the operation in flight.
- Wrap-around: the result is modulo 2^WIDTH. Carry out of the MSB appears only on c_out.
- Reset asserted mid-operation abandons the operation immediately: done never pulses and all outputs read 0.
- With CHUNK = WIDTH the operation still takes one RUN cycle. Latency is 1, with done after the first edge following start.

Test Plan:
1. WIDTH=8, CHUNK=1: a=8'hFF, b=8'h01, c_in=0, sub=0 → after 8 cycles: done pulse, sum=8'h00, c_out=1, ovf=0, zero=1.
2. WIDTH=8, CHUNK=1: a=8'h7F, b=8'h01, sub=0 → sum=8'h80, c_out=0, ovf=1, zero=0. Then a=8'h05, b=8'h07, sub=1, c_in=1 (ignored) → sum=8'hFE, c_out=0, ovf=0.
3. WIDTH=16, CHUNK=4: a=16'h1234, b=16'h0FFF, c_in=1 → done exactly 4 cycles after start, sum=16'h2234, c_out=0. Back-to-back start in the DONE cycle with a=16'h8000, b=16'h8000 → sum=16'h0000, c_out=1, ovf=1, zero=1.
4. Protocol check:
   - Pulse start again 3 cycles into a WIDTH=8, CHUNK=1 operation with different operands → ignored; the first result is unchanged and done pulses once.
   - Change a and b during RUN → result still reflects the latched values.
5. Reset mid-operation: deassert rst_n asynchronously (between edges) at cycle 4 of 8 → busy, done, sum and flags go to 0 immediately. No done pulse follows. A new start after release completes normally.
6. Exhaustive check, WIDTH=4, CHUNK ∈ {1, 2, 4}: all 2×2×16×16 combinations of {sub, c_in, a, b} compared against a behavioural model for sum, c_out, ovf and zero, and for latency = NCHUNK. Results are written to the team's output log file.

Source files
------------

// File: rtl/chunked_adder.sv
// Multi-cycle add/subtract unit: one shared CHUNK-bit adder slice walks the
// operands LSB-chunk first behind a start/done handshake, producing sum and flags.
module chunked_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned SW     = CHUNK + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]       a_r, b_r, res_r;
    logic                   carry_r;
    logic [CW-1:0]          cnt;

    logic                   accept, last;
    logic [CHUNK-1:0]       a_lo, b_lo, s_lo;
    logic                   slice_cout, msb_cin;
    logic [WIDTH+CHUNK-1:0] res_cat;
    logic [WIDTH-1:0]       res_next;
    logic                   busy_next, done_next;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; a start in the DONE cycle is taken just like in IDLE
    always_comb begin
        state_next = state;
        accept     = start && (state != RUN);
        last       = (cnt == CW'(NCHUNK - 1));
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: handshake flags follow the state being entered
    always_comb begin
        busy_next = (state_next == RUN);
        done_next = (state_next == DONE);
    end

    // Shared adder slice on the low chunk of the shifting operand registers
    always_comb begin
        a_lo                 = a_r[CHUNK-1:0];
        b_lo                 = b_r[CHUNK-1:0];
        {slice_cout, s_lo}   = SW'(a_lo) + SW'(b_lo) + SW'(carry_r);
        msb_cin              = a_lo[CHUNK-1] ^ b_lo[CHUNK-1] ^ s_lo[CHUNK-1];
        res_cat              = {s_lo, res_r};
        res_next             = res_cat[WIDTH+CHUNK-1:CHUNK];
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            res_r   <= '0;
            carry_r <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            c_out   <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
        end else begin
            busy <= busy_next;
            done <= done_next;
            if (accept) begin
                a_r     <= a;
                b_r     <= sub ? ~b : b;
                carry_r <= sub ? 1'b1 : c_in;
                cnt     <= '0;
            end else if (state == RUN) begin
                a_r     <= a_r >> CHUNK;
                b_r     <= b_r >> CHUNK;
                res_r   <= res_next;
                carry_r <= slice_cout;
                cnt     <= cnt + CW'(1);
                if (last) begin
                    sum   <= res_next;
                    c_out <= slice_cout;
                    ovf   <= msb_cin ^ slice_cout;
                    zero  <= (res_next == '0);
                end
            end
        end
    end

endmodule
